// File: rtl/param_shift_unit_if.sv
// Handshake and data bundle between a requester and the param_shift_unit.
// The master drives the request; the slave (the shifter) returns status and result.
interface param_shift_unit_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
);
    logic             start;
    logic [1:0]       mode;
    logic [AW-1:0]    shift_amt;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic             carry_out;

    modport master (
        output start, mode, shift_amt, data_in,
        input  busy, done, data_out, carry_out
    );

    modport slave (
        input  start, mode, shift_amt, data_in,
        output busy, done, data_out, carry_out
    );
endinterface

// File: rtl/param_shift_unit.sv
// Serial shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Supports LSL, LSR, ASR and ROR with a carry-out of the last bit moved out.
module param_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input logic               clock,
    input logic               reset,
    param_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
    typedef enum logic [1:0] {MODE_LSL = 2'b00, MODE_LSR = 2'b01,
                              MODE_ASR = 2'b10, MODE_ROR = 2'b11} mode_e;

    localparam logic [AW-1:0] MAX_AMT = AW'(WIDTH);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             wcarry_q, wcarry_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] step_val;
    logic             step_carry;
    logic [AW-1:0]    amt_clamped;

    assign amt_clamped = (bus.shift_amt > MAX_AMT) ? MAX_AMT : bus.shift_amt;

    // One-position step of the working register in the latched mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        step_val   = work_q;
        step_carry = work_q[0];
        unique case (mode_q)
            MODE_LSL: begin
                step_val   = {work_q[WIDTH-2:0], 1'b0};
                step_carry = work_q[WIDTH-1];
            end
            MODE_LSR: step_val = {1'b0, work_q[WIDTH-1:1]};
            MODE_ASR: step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            MODE_ROR: step_val = {work_q[0], work_q[WIDTH-1:1]};
            default:  step_val = work_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        wcarry_d   = wcarry_q;
        data_out_d = data_out_q;
        carry_d    = carry_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_SHIFT;
                    mode_d   = mode_e'(bus.mode);
                    work_d   = bus.data_in;
                    cnt_d    = amt_clamped;
                    wcarry_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    work_d   = step_val;
                    wcarry_d = step_carry;
                    cnt_d    = cnt_q - AW'(1);
                end else begin
                    // Results are published only on completion; they hold otherwise.
                    data_out_d = work_q;
                    carry_d    = wcarry_q;
                    state_d    = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_LSL;
            work_q     <= '0;
            cnt_q      <= '0;
            wcarry_q   <= 1'b0;
            data_out_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            wcarry_q   <= wcarry_d;
            data_out_q <= data_out_d;
            carry_q    <= carry_d;
        end
    end

    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.data_out  = data_out_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit at WIDTH=8: latency, modes, clamp,
// handshake, back-to-back and mid-operation reset.
module tb_param_shift_unit;
    localparam int WIDTH = 8;
    localparam int AW    = 4;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    param_shift_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    param_shift_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issues one operation and waits for busy to fall; returns what was observed.
    task automatic run_op(input logic [1:0] m, input logic [AW-1:0] amt,
                          input logic [WIDTH-1:0] d, output int busy_cycles,
                          output logic done_seen, output logic [WIDTH-1:0] res,
                          output logic cry);
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.shift_amt = amt;
        bus.data_in   = d;
        tick();
        bus.start   = 1'b0;
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            tick();
        end
        done_seen = bus.done;
        res       = bus.data_out;
        cry       = bus.carry_out;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.mode      = LSL;
        bus.shift_amt = 4'd3;
        bus.data_in   = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.busy, bus.done, bus.data_out, bus.carry_out} !== 11'd0) begin
                failures++;
                $display("FAIL reset_state edge%0d: busy=%b done=%b data_out=%h carry=%b, want all 0",
                         i, bus.busy, bus.done, bus.data_out, bus.carry_out);
            end
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_lsl_latency;
        int cyc; logic dn; logic [WIDTH-1:0] r; logic c;
        run_op(LSL, 4'd3, 8'hB5, cyc, dn, r, c);
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL lsl_busy_cycles: got %0d want 4", cyc);
        end
        checks++;
        if ({dn, r, c} !== {1'b1, 8'hA8, 1'b1}) begin
            failures++;
            $display("FAIL lsl_result: done=%b data=%h carry=%b want done=1 data=a8 carry=1", dn, r, c);
        end
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.data_out} !== {1'b0, 1'b0, 8'hA8}) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b busy=%b data=%h want 0 0 a8",
                     bus.done, bus.busy, bus.data_out);
        end
    endtask

    task automatic test_modes;
        logic [1:0]       m   [4] = '{ASR, LSR, ROR, ROR};
        logic [AW-1:0]    amt [4] = '{4'd4, 4'd4, 4'd1, 4'd8};
        logic [WIDTH-1:0] din [4] = '{8'h90, 8'h90, 8'h81, 8'h5A};
        logic [WIDTH-1:0] exp [4] = '{8'hF9, 8'h09, 8'hC0, 8'h5A};
        logic             ec  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            int cyc; logic dn; logic [WIDTH-1:0] r; logic c;
            run_op(m[i], amt[i], din[i], cyc, dn, r, c);
            checks++;
            if ({dn, r, c} !== {1'b1, exp[i], ec[i]} || cyc !== int'(amt[i]) + 1) begin
                failures++;
                $display("FAIL mode_%0d: done=%b data=%h carry=%b cycles=%0d want 1 %h %b %0d",
                         i, dn, r, c, cyc, exp[i], ec[i], int'(amt[i]) + 1);
            end
            tick();
        end
    endtask

    task automatic test_zero_clamp;
        int cyc; logic dn; logic [WIDTH-1:0] r; logic c;
        run_op(LSL, 4'd0, 8'h3C, cyc, dn, r, c);
        checks++;
        if ({dn, r, c} !== {1'b1, 8'h3C, 1'b0} || cyc !== 1) begin
            failures++;
            $display("FAIL zero_amount: done=%b data=%h carry=%b cycles=%0d want 1 3c 0 1", dn, r, c, cyc);
        end
        tick();
        run_op(LSL, 4'd12, 8'hFF, cyc, dn, r, c);
        checks++;
        if ({dn, r, c} !== {1'b1, 8'h00, 1'b1} || cyc !== 9) begin
            failures++;
            $display("FAIL clamp_amount: done=%b data=%h carry=%b cycles=%0d want 1 00 1 9", dn, r, c, cyc);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int   cyc;
        logic hold_ok;
        hold_ok       = 1'b1;
        bus.start     = 1'b1;
        bus.mode      = LSR;
        bus.shift_amt = 4'd5;
        bus.data_in   = 8'h80;
        tick();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 50) begin
            // Previous result (clamped LSL) must hold while shifting.
            if (bus.data_out !== 8'h00 || bus.carry_out !== 1'b1) hold_ok = 1'b0;
            bus.data_in   = 8'hFF ^ (8'h11 * 8'(cyc + 1));
            bus.mode      = 2'(cyc);
            bus.shift_amt = 4'(cyc);
            cyc++;
            tick();
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            failures++;
            $display("FAIL result_hold: data_out/carry changed during SHIFT, want 00/1 held");
        end
        checks++;
        if ({bus.done, bus.data_out, bus.carry_out} !== {1'b1, 8'h04, 1'b0} || cyc !== 6) begin
            failures++;
            $display("FAIL ignored_starts: done=%b data=%h carry=%b cycles=%0d want 1 04 0 6",
                     bus.done, bus.data_out, bus.carry_out, cyc);
        end
        bus.start     = 1'b1;
        bus.mode      = ROR;
        bus.shift_amt = 4'd1;
        bus.data_in   = 8'h01;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.data_out} !== {1'b1, 1'b0, 8'h04}) begin
            failures++;
            $display("FAIL start_in_done: busy=%b done=%b data=%h want 1 0 04",
                     bus.busy, bus.done, bus.data_out);
        end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 50) begin
            cyc++;
            tick();
        end
        checks++;
        if ({bus.done, bus.data_out, bus.carry_out} !== {1'b1, 8'h80, 1'b1} || cyc !== 2) begin
            failures++;
            $display("FAIL second_done: done=%b data=%h carry=%b cycles=%0d want 1 80 1 2",
                     bus.done, bus.data_out, bus.carry_out, cyc);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int   cyc; logic dn; logic [WIDTH-1:0] r; logic c;
        logic quiet;
        bus.start     = 1'b1;
        bus.mode      = LSL;
        bus.shift_amt = 4'd7;
        bus.data_in   = 8'h01;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.data_out, bus.carry_out} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b data=%h carry=%b want 0 0 00 0",
                     bus.busy, bus.done, bus.data_out, bus.carry_out);
        end
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort: busy or done seen after mid-operation reset, want both 0");
        end
        run_op(LSL, 4'd7, 8'h01, cyc, dn, r, c);
        checks++;
        if ({dn, r, c} !== {1'b1, 8'h80, 1'b0} || cyc !== 8) begin
            failures++;
            $display("FAIL after_reset_op: done=%b data=%h carry=%b cycles=%0d want 1 80 0 8", dn, r, c, cyc);
        end
        tick();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.shift_amt = '0;
        bus.data_in   = '0;
        test_reset();
        test_lsl_latency();
        test_modes();
        test_zero_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
